// File: rtl/stat_display_ctrl.sv
// stat_display_ctrl: 8-digit hex display of one of five 32-bit statistics, chosen with a debounced button
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   total_cycles .. SyscallOut    statistics sources 0..4
//   btn_next                      raw bouncing button, advances the selected source
//   hold                          freezes the displayed value at frame boundaries
//   an, seg                       active-low digit enables and {g,f,e,d,c,b,a} segments
//   src_sel                       currently selected source, 0..4
//   frame_tick                    one-cycle pulse on the last cycle of each 8-digit frame
module stat_display_ctrl #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] total_cycles,
    input  logic [31:0] uncondi_num,
    input  logic [31:0] condi_num,
    input  logic [31:0] condi_suc_num,
    input  logic [31:0] SyscallOut,
    input  logic        btn_next,
    input  logic        hold,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic [2:0]  src_sel,
    output logic        frame_tick
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_PRE = SW'(SCAN_DIV - 2);
    localparam logic [DW-1:0] DEB_TC   = DW'(DEB_CYCLES - 1);

    logic          sync0, sync1, stable, load_pending, next_pulse, scan_tc;
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] div_cnt;
    logic [2:0]    digit_idx;
    logic [31:0]   snapshot, src_val;
    logic [3:0]    nibble;
    logic [6:0]    seg_d;

    // Rising acceptance of the debounced level, asserted in the cycle stable is about to go 0->1.
    assign next_pulse = sync1 & ~stable & (deb_cnt == DEB_TC);
    assign scan_tc    = div_cnt == SCAN_TC;

    always_comb begin
        src_val = src_sel == 3'd0 ? total_cycles :
                  src_sel == 3'd1 ? uncondi_num  :
                  src_sel == 3'd2 ? condi_num    :
                  src_sel == 3'd3 ? condi_suc_num : SyscallOut;
        nibble  = snapshot[{digit_idx, 2'b00} +: 4];
    end

    always_comb begin
        case (nibble)
            4'h0:    seg_d = 7'b1000000;
            4'h1:    seg_d = 7'b1111001;
            4'h2:    seg_d = 7'b0100100;
            4'h3:    seg_d = 7'b0110000;
            4'h4:    seg_d = 7'b0011001;
            4'h5:    seg_d = 7'b0010010;
            4'h6:    seg_d = 7'b0000010;
            4'h7:    seg_d = 7'b1111000;
            4'h8:    seg_d = 7'b0000000;
            4'h9:    seg_d = 7'b0010000;
            4'hA:    seg_d = 7'b0001000;
            4'hB:    seg_d = 7'b0000011;
            4'hC:    seg_d = 7'b1000110;
            4'hD:    seg_d = 7'b0100001;
            4'hE:    seg_d = 7'b0000110;
            default: seg_d = 7'b0001110;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0        <= 1'b0;
            sync1        <= 1'b0;
            stable       <= 1'b0;
            deb_cnt      <= '0;
            src_sel      <= 3'd0;
            load_pending <= 1'b0;
            snapshot     <= 32'd0;
            div_cnt      <= '0;
            digit_idx    <= 3'd0;
            frame_tick   <= 1'b0;
            an           <= 8'hFE;
            seg          <= 7'b1000000;
        end else begin
            sync0        <= btn_next;
            sync1        <= sync0;
            deb_cnt      <= (sync1 == stable || deb_cnt == DEB_TC) ? '0 : deb_cnt + 1'b1;
            if (sync1 != stable && deb_cnt == DEB_TC)
                stable <= sync1;
            if (next_pulse)
                src_sel <= src_sel == 3'd4 ? 3'd0 : src_sel + 3'd1;
            // A pending load always follows the pulse by one edge, so a coincident
            // frame load takes the old source and the pending load the new one.
            load_pending <= next_pulse;
            if (load_pending || (frame_tick && !hold))
                snapshot <= src_val;
            div_cnt      <= scan_tc ? '0 : div_cnt + 1'b1;
            if (scan_tc)
                digit_idx <= digit_idx + 3'd1;
            // Registered one cycle early so it is high exactly at terminal count of digit 7.
            frame_tick   <= div_cnt == SCAN_PRE && digit_idx == 3'd7;
            an           <= ~(8'b1 << digit_idx);
            seg          <= seg_d;
        end
    end
endmodule

// File: tb/tb_stat_display_ctrl.sv
// tb_stat_display_ctrl: directed self-checking bench for stat_display_ctrl (SCAN_DIV=4, DEB_CYCLES=3)
module tb_stat_display_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut;
    logic        btn_next, hold;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [2:0]  src_sel;
    logic        frame_tick;
    int          passed = 0;
    int          total = 0;

    stat_display_ctrl #(.SCAN_DIV(4), .DEB_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .total_cycles(total_cycles), .uncondi_num(uncondi_num), .condi_num(condi_num),
        .condi_suc_num(condi_suc_num), .SyscallOut(SyscallOut),
        .btn_next(btn_next), .hold(hold),
        .an(an), .seg(seg), .src_sel(src_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_an(input logic [7:0] a);
        int n = 0;
        while (an !== a && n < 40) begin
            tick(1);
            n++;
        end
        chk("an_wait", {24'd0, an}, {24'd0, a});
    endtask

    task automatic press(input logic [2:0] exp);
        btn_next = 1'b1;
        tick(5);
        chk("press_src_sel", {29'd0, src_sel}, {29'd0, exp});
        tick(1);
        btn_next = 1'b0;
        tick(6);
    endtask

    initial begin
        rst = 1'b1;
        btn_next = 1'b0;
        hold = 1'b0;
        total_cycles  = 32'h12345678;
        uncondi_num   = 32'h9ABCDEF0;
        condi_num     = 32'h0F1E2D3C;
        condi_suc_num = 32'hA5A5A5A5;
        SyscallOut    = 32'h00C0FFEE;
        tick(2);
        chk("rst_an", {24'd0, an}, 32'hFE);
        chk("rst_seg", {25'd0, seg}, 32'h40);
        chk("rst_src_sel", {29'd0, src_sel}, 32'd0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;
        tick(30);
        chk("ft_before", {31'd0, frame_tick}, 32'd0);
        tick(1);
        chk("ft_cycle32", {31'd0, frame_tick}, 32'd1);
        tick(1);
        chk("ft_after", {31'd0, frame_tick}, 32'd0);
        tick(1);
        chk("digit0_an", {24'd0, an}, 32'hFE);
        chk("digit0_seg8", {25'd0, seg}, 32'h00);
        tick(4);
        chk("digit1_an", {24'd0, an}, 32'hFD);
        chk("digit1_seg7", {25'd0, seg}, 32'h78);
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            tick(2);
        end
        chk("bounce_src_sel", {29'd0, src_sel}, 32'd0);
        tick(4);
        chk("bounce_src_sel_late", {29'd0, src_sel}, 32'd0);
        btn_next = 1'b1;
        tick(4);
        chk("press_early", {29'd0, src_sel}, 32'd0);
        tick(1);
        chk("press_accept", {29'd0, src_sel}, 32'd1);
        tick(6);
        chk("press_once", {29'd0, src_sel}, 32'd1);
        btn_next = 1'b0;
        tick(8);
        chk("release_no_pulse", {29'd0, src_sel}, 32'd1);
        press(3'd2);
        press(3'd3);
        press(3'd4);
        press(3'd0);
        hold = 1'b1;
        total_cycles = 32'hDEADBEEF;
        for (int f = 0; f < 4; f++) begin
            wait_an(8'hFE);
            chk("hold_digit0", {25'd0, seg}, 32'h00);
            wait_an(8'h7F);
            chk("hold_digit7", {25'd0, seg}, 32'h79);
        end
        press(3'd1);
        wait_an(8'hFE);
        chk("hold_press_digit0", {25'd0, seg}, 32'h40);
        wait_an(8'h7F);
        chk("hold_press_digit7", {25'd0, seg}, 32'h10);
        hold = 1'b0;
        uncondi_num = 32'h00000003;
        tick(40);
        wait_an(8'hFE);
        chk("unhold_digit0", {25'd0, seg}, 32'h30);
        wait_an(8'h7F);
        chk("unhold_digit7", {25'd0, seg}, 32'h40);
        wait_an(8'hDF);
        rst = 1'b1;
        tick(1);
        chk("midrst_an", {24'd0, an}, 32'hFE);
        chk("midrst_seg", {25'd0, seg}, 32'h40);
        chk("midrst_src_sel", {29'd0, src_sel}, 32'd0);
        chk("midrst_frame_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;
        tick(27);
        btn_next = 1'b1;
        tick(3);
        chk("sim_ft_before", {31'd0, frame_tick}, 32'd0);
        tick(1);
        chk("sim_ft", {31'd0, frame_tick}, 32'd1);
        chk("sim_src_old", {29'd0, src_sel}, 32'd0);
        tick(1);
        chk("sim_src_new", {29'd0, src_sel}, 32'd1);
        chk("sim_ft_after", {31'd0, frame_tick}, 32'd0);
        tick(1);
        chk("sim_seg_old_src", {25'd0, seg}, 32'h0E);
        tick(1);
        chk("sim_seg_new_src", {25'd0, seg}, 32'h30);
        btn_next = 1'b0;
        tick(8);
        chk("final_src_sel", {29'd0, src_sel}, 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
